// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that serialises read/write transactions from NUM_PROC
// requesting channels onto a single-port memory, routes the completion back
// to the owning channel and aborts transactions that the memory does not
// finish within TIMEOUT BUSY cycles (TIMEOUT = 0 disables the abort).
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   proc_read_req       per-channel read request (level)
//   proc_write_req      per-channel write request (level, wins over read)
//   proc_addr           packed per-channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   proc_write_data     packed per-channel write data, channel i at [i*DATA_W +: DATA_W]
//   proc_grant          one-hot owner of the current transaction, 0 when idle
//   proc_done           one-cycle completion pulse to the owner
//   proc_err            one-cycle abort pulse, coincident with proc_done
//   proc_read_data      data of the last successfully completed read
//   mem_read_req        read strobe, level while BUSY
//   mem_write_req       write strobe, level while BUSY
//   mem_addr            latched owner address
//   mem_write_data      latched owner write data
//   mem_done            memory completion, only looked at in BUSY
//   mem_read_data       memory read data, valid with mem_done
//   fsm_state           debug view of the controller state (0 IDLE, 1 BUSY, 2 RESP)
//
// Handshake: a channel raises read and/or write request and holds it (with
// stable address/data) until it sees proc_done high; it drops the request at
// that same edge. Requests are only sampled in IDLE, so a channel in RESP is
// never re-granted on its stale request. Towards memory, a strobe stays high
// from the grant until mem_done (or the abort), and the transaction finishes
// at the edge where mem_done is sampled high.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NUM_PROC = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_PROC-1:0]          proc_read_req,
    input  logic [NUM_PROC-1:0]          proc_write_req,
    input  logic [NUM_PROC*ADDR_W-1:0]   proc_addr,
    input  logic [NUM_PROC*DATA_W-1:0]   proc_write_data,
    output logic [NUM_PROC-1:0]          proc_grant,
    output logic [NUM_PROC-1:0]          proc_done,
    output logic [NUM_PROC-1:0]          proc_err,
    output logic [DATA_W-1:0]            proc_read_data,
    output logic                         mem_read_req,
    output logic                         mem_write_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_write_data,
    input  logic                         mem_done,
    input  logic [DATA_W-1:0]            mem_read_data,
    output logic [1:0]                   fsm_state
);

    localparam int IDX_W = $clog2(NUM_PROC);
    // A zero-width counter is illegal, so keep one bit when the abort is off.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    // last_q is both the round-robin pointer and the owner of the transaction
    // in flight: the winner becomes "last" at the very edge it is granted.
    logic [IDX_W-1:0]     last_q;
    logic                 op_write_q;
    logic                 err_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rdata_q;

    logic [NUM_PROC-1:0]  req;
    logic                 any_req;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [IDX_W:0]       cand;
    logic [NUM_PROC-1:0]  owner_onehot;

    logic                 grant_take;
    logic                 finish;
    logic                 finish_err;
    logic                 cnt_inc;

    assign req     = proc_read_req | proc_write_req;
    assign any_req = |req;

    // Search upward from last+1 with wrap. cand is one bit wider than an
    // index so last+offset never overflows before the wrap subtraction.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_PROC; off++) begin
            cand = {1'b0, last_q} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(NUM_PROC)) begin
                cand = cand - (IDX_W + 1)'(NUM_PROC);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d    = S_BUSY;
                    grant_take = 1'b1;
                end
            end
            S_BUSY: begin
                // mem_done has priority so a completion on the last allowed
                // cycle is a normal completion, not an abort.
                if (mem_done) begin
                    state_d = S_RESP;
                    finish  = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d    = S_RESP;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= IDX_W'(NUM_PROC - 1);
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (grant_take) begin
                last_q     <= win_idx;
                op_write_q <= proc_write_req[win_idx];
                addr_q     <= proc_addr[win_idx*ADDR_W +: ADDR_W];
                wdata_q    <= proc_write_data[win_idx*DATA_W +: DATA_W];
                cnt_q      <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                err_q <= finish_err;
                if (!op_write_q && !finish_err) begin
                    rdata_q <= mem_read_data;
                end
            end
        end
    end

    assign owner_onehot = NUM_PROC'(1) << last_q;

    // Outputs decode from registered state only, so an asynchronous reset
    // drops grant and strobes immediately and no done pulse can follow.
    always_comb begin
        proc_grant    = '0;
        proc_done     = '0;
        proc_err      = '0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        case (state_q)
            S_BUSY: begin
                proc_grant    = owner_onehot;
                mem_read_req  = !op_write_q;
                mem_write_req = op_write_q;
            end
            S_RESP: begin
                proc_grant = owner_onehot;
                proc_done  = owner_onehot;
                proc_err   = err_q ? owner_onehot : '0;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign proc_read_data = rdata_q;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. Main instance uses TIMEOUT=8; a second instance with
// TIMEOUT=0 has its own requests and mem_done and shares address/data inputs.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- stimulus ----------------
    logic [NP-1:0]    rd_req, wr_req, rd_req0, wr_req0;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic             mem_done, mem_done0;
    logic [DW-1:0]    mem_rdata;

    // ---------------- DUT outputs ----------------
    logic [NP-1:0] grant, done, err;
    logic [DW-1:0] prd, mwdata;
    logic [AW-1:0] maddr;
    logic          mrd, mwr;
    logic [1:0]    state;

    logic [NP-1:0] grant_z, done_z, err_z;
    logic [DW-1:0] prd_z, mwdata_z;
    logic [AW-1:0] maddr_z;
    logic          mrd_z, mwr_z;
    logic [1:0]    state_z;

    mem_arbiter #(.NUM_PROC(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .proc_read_req(rd_req), .proc_write_req(wr_req),
        .proc_addr(addr), .proc_write_data(wdata),
        .proc_grant(grant), .proc_done(done), .proc_err(err),
        .proc_read_data(prd),
        .mem_read_req(mrd), .mem_write_req(mwr),
        .mem_addr(maddr), .mem_write_data(mwdata),
        .mem_done(mem_done), .mem_read_data(mem_rdata),
        .fsm_state(state)
    );

    mem_arbiter #(.NUM_PROC(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .proc_read_req(rd_req0), .proc_write_req(wr_req0),
        .proc_addr(addr), .proc_write_data(wdata),
        .proc_grant(grant_z), .proc_done(done_z), .proc_err(err_z),
        .proc_read_data(prd_z),
        .mem_read_req(mrd_z), .mem_write_req(mwr_z),
        .mem_addr(maddr_z), .mem_write_data(mwdata_z),
        .mem_done(mem_done0), .mem_read_data(mem_rdata),
        .fsm_state(state_z)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[ch*AW +: AW]  = a;
        wdata[ch*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b1;
        rd_req = '0; wr_req = '0; rd_req0 = '0; wr_req0 = '0;
        addr = '0; wdata = '0; mem_done = 1'b0; mem_done0 = 1'b0; mem_rdata = '0;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, done, err, mrd, mwr, state} !== '0 || prd !== '0 || maddr !== '0 || mwdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b done=%b err=%b mrd=%b mwr=%b st=%0d prd=%h maddr=%h mwd=%h, expected all 0",
                     grant, done, err, mrd, mwr, state, prd, maddr, mwdata);
        end
        checks++;
        if ({grant_z, done_z, err_z, mrd_z, mwr_z, state_z} !== '0 || prd_z !== '0) begin
            errors++;
            $display("FAIL reset_outputs_t0: got grant=%b done=%b err=%b prd=%h, expected all 0", grant_z, done_z, err_z, prd_z);
        end
        tick();
        reset_n = 1'b1;
        tick();
        // mem_done outside BUSY must be ignored
        mem_done = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        tick();
        mem_done = 1'b0;
        checks++;
        if (prd !== '0 || done !== '0 || grant !== '0 || state !== 2'd0) begin
            errors++;
            $display("FAIL idle_mem_done: got prd=%h done=%b grant=%b st=%0d, expected 0 0 0 0", prd, done, grant, state);
        end
    endtask

    task automatic test_single_read();
        set_ch(2, 14'h0123, 16'h0000);
        rd_req = 4'b0100;
        tick();
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (grant !== 4'b0100 || maddr !== 14'h0123 || mrd !== 1'b1 || mwr !== 1'b0 || done !== '0) begin
                errors++;
                $display("FAIL single_busy%0d: got grant=%b maddr=%h mrd=%b mwr=%b done=%b, expected 0100 0123 1 0 0000",
                         c, grant, maddr, mrd, mwr, done);
            end
            addr[2*AW +: AW] = 14'h1111; // inputs move; latched address must not
            if (c == 3) begin
                mem_done = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            tick();
        end
        mem_done = 1'b0;
        checks++;
        if (done !== 4'b0100 || err !== '0 || grant !== 4'b0100 || maddr !== 14'h0123 || mrd !== 1'b0 || prd !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_resp: got done=%b err=%b grant=%b maddr=%h mrd=%b prd=%h, expected 0100 0000 0100 0123 0 beef",
                     done, err, grant, maddr, mrd, prd);
        end
        rd_req = '0;
        tick();
        checks++;
        if (done !== '0 || grant !== '0 || prd !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_idle: got done=%b grant=%b prd=%h, expected 0000 0000 beef", done, grant, prd);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        apply_reset();
        for (int ch = 0; ch < NP; ch++) set_ch(ch, AW'(14'h0100 + ch), '0);
        rd_req = 4'hF;
        for (int i = 0; i < 6; i++) begin
            exp = i % NP;
            tick();
            checks++;
            if (grant !== (4'b0001 << exp) || mrd !== 1'b1 || maddr !== AW'(14'h0100 + exp)) begin
                errors++;
                $display("FAIL rr_grant%0d: got grant=%b mrd=%b maddr=%h, expected %b 1 %h",
                         i, grant, mrd, maddr, 4'b0001 << exp, AW'(14'h0100 + exp));
            end
            tick();
            mem_done = 1'b1;
            mem_rdata = DW'(16'h1000 + i);
            tick();
            mem_done = 1'b0;
            checks++;
            if (done !== (4'b0001 << exp) || err !== '0 || prd !== DW'(16'h1000 + i)) begin
                errors++;
                $display("FAIL rr_done%0d: got done=%b err=%b prd=%h, expected %b 0000 %h",
                         i, done, err, prd, 4'b0001 << exp, DW'(16'h1000 + i));
            end
            tick();
            checks++;
            if (grant !== '0 || mrd !== 1'b0 || state !== 2'd0) begin
                errors++;
                $display("FAIL rr_idle%0d: got grant=%b mrd=%b st=%0d, expected 0000 0 0", i, grant, mrd, state);
            end
        end
        rd_req = '0;
        tick();
    endtask

    task automatic test_write_priority();
        logic [DW-1:0] prev;
        prev = prd;
        set_ch(1, 14'h3FFF, 16'h5A5A);
        rd_req = 4'b0010;
        wr_req = 4'b0010;
        tick();
        checks++;
        if (mwr !== 1'b1 || mrd !== 1'b0 || mwdata !== 16'h5A5A || maddr !== 14'h3FFF || grant !== 4'b0010) begin
            errors++;
            $display("FAIL wr_busy: got mwr=%b mrd=%b mwd=%h maddr=%h grant=%b, expected 1 0 5a5a 3fff 0010",
                     mwr, mrd, mwdata, maddr, grant);
        end
        mem_done = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_done = 1'b0;
        checks++;
        if (done !== 4'b0010 || err !== '0 || prd !== prev) begin
            errors++;
            $display("FAIL wr_resp: got done=%b err=%b prd=%h, expected 0010 0000 %h", done, err, prd, prev);
        end
        rd_req = '0;
        wr_req = '0;
        tick();
    endtask

    task automatic test_timeout();
        int  strobe_cycles;
        bit  saw_done;
        strobe_cycles = 0;
        saw_done = 1'b0;
        set_ch(3, 14'h0333, '0);
        rd_req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done !== '0) begin
                saw_done = 1'b1;
                break;
            end
            if (mrd === 1'b1) strobe_cycles++;
        end
        checks++;
        if (!saw_done || strobe_cycles != TO) begin
            errors++;
            $display("FAIL to_length: got done_seen=%0d strobe_cycles=%0d, expected 1 %0d", saw_done, strobe_cycles, TO);
        end
        checks++;
        if (done !== 4'b1000 || err !== 4'b1000 || mrd !== 1'b0) begin
            errors++;
            $display("FAIL to_resp: got done=%b err=%b mrd=%b, expected 1000 1000 0", done, err, mrd);
        end
        rd_req = '0;
        tick();
        checks++;
        if (done !== '0 || err !== '0) begin
            errors++;
            $display("FAIL to_pulse: got done=%b err=%b, expected 0000 0000", done, err);
        end
        set_ch(0, 14'h0055, '0);
        rd_req = 4'b0001;
        tick();
        mem_done = 1'b1;
        mem_rdata = 16'h7777;
        checks++;
        if (grant !== 4'b0001 || mrd !== 1'b1) begin
            errors++;
            $display("FAIL to_next_grant: got grant=%b mrd=%b, expected 0001 1", grant, mrd);
        end
        tick();
        mem_done = 1'b0;
        checks++;
        if (done !== 4'b0001 || err !== '0 || prd !== 16'h7777) begin
            errors++;
            $display("FAIL to_next_done: got done=%b err=%b prd=%h, expected 0001 0000 7777", done, err, prd);
        end
        rd_req = '0;
        tick();
    endtask

    task automatic test_timeout_boundary();
        int early;
        int bad;
        early = 0;
        set_ch(0, 14'h0042, '0);
        rd_req = 4'b0001;
        tick();
        for (int c = 1; c <= TO; c++) begin
            if (done !== '0) early++;
            if (c == TO) begin
                mem_done = 1'b1;
                mem_rdata = 16'h0042;
            end
            tick();
        end
        mem_done = 1'b0;
        checks++;
        if (early != 0 || done !== 4'b0001 || err !== '0 || prd !== 16'h0042) begin
            errors++;
            $display("FAIL to_boundary: got early=%0d done=%b err=%b prd=%h, expected 0 0001 0000 0042", early, done, err, prd);
        end
        rd_req = '0;
        tick();
        // timeout disabled: 200 cycles of waiting must not abort
        bad = 0;
        set_ch(1, 14'h0201, '0);
        rd_req0 = 4'b0010;
        tick();
        for (int c = 1; c <= 200; c++) begin
            if (mrd_z !== 1'b1 || done_z !== '0 || err_z !== '0 || grant_z !== 4'b0010) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t0_wait: got %0d bad BUSY cycles, expected 0", bad);
        end
        mem_done0 = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        mem_done0 = 1'b0;
        checks++;
        if (done_z !== 4'b0010 || err_z !== '0 || prd_z !== 16'hCAFE) begin
            errors++;
            $display("FAIL t0_done: got done=%b err=%b prd=%h, expected 0010 0000 cafe", done_z, err_z, prd_z);
        end
        rd_req0 = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_ch(1, 14'h0AAA, 16'h1234);
        wr_req = 4'b0010;
        tick();
        tick();
        checks++;
        if (mwr !== 1'b1 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_pre: got mwr=%b grant=%b, expected 1 0010", mwr, grant);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (mwr !== 1'b0 || grant !== '0 || done !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got mwr=%b grant=%b done=%b, expected 0 0000 0000", mwr, grant, done);
        end
        tick();
        checks++;
        if (done !== '0 || err !== '0) begin
            errors++;
            $display("FAIL rst_mid_nodone: got done=%b err=%b, expected 0000 0000", done, err);
        end
        reset_n = 1'b1;
        wr_req = '0;
        set_ch(0, 14'h0010, '0);
        rd_req = 4'b0011;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_first: got grant=%b, expected 0001", grant);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        checks++;
        if (done !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_done0: got done=%b, expected 0001", done);
        end
        rd_req = 4'b0010;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_second: got grant=%b, expected 0010", grant);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        rd_req = '0;
        tick();
    endtask

    // Random traffic against a transaction-level model: pending requests per
    // channel, winner found by modular search from the last winner, latency
    // chosen up front so the outcome (done or abort) is known in advance.
    task automatic test_random();
        int            last;
        int            win;
        int            lat;
        int            busy;
        bit            got;
        bit            is_wr;
        bit            exp_err;
        int            exp_busy;
        int            op;
        logic [NP-1:0] pend_rd, pend_wr;
        logic [AW-1:0] a_ch[NP];
        logic [DW-1:0] d_ch[NP];
        logic [DW-1:0] model_prd;
        logic [DW-1:0] rd_val;
        logic [DW-1:0] exp_prd;

        apply_reset();
        last = NP - 1;
        model_prd = '0;
        pend_rd = '0;
        pend_wr = '0;
        for (int ch = 0; ch < NP; ch++) begin
            a_ch[ch] = '0;
            d_ch[ch] = '0;
        end

        for (int t = 0; t < 40; t++) begin
            for (int ch = 0; ch < NP; ch++) begin
                if (!(pend_rd[ch] || pend_wr[ch]) && $urandom_range(0, 1) == 1) begin
                    op = $urandom_range(0, 2);
                    pend_rd[ch] = (op != 1);
                    pend_wr[ch] = (op != 0);
                    a_ch[ch] = AW'($urandom);
                    d_ch[ch] = DW'($urandom);
                end
                set_ch(ch, a_ch[ch], d_ch[ch]);
            end
            rd_req = pend_rd;
            wr_req = pend_wr;

            if ((pend_rd | pend_wr) == '0) begin
                tick();
                checks++;
                if (grant !== '0 || mrd !== 1'b0 || mwr !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle%0d: got grant=%b mrd=%b mwr=%b, expected 0000 0 0", t, grant, mrd, mwr);
                end
                continue;
            end

            win = -1;
            for (int off = 1; off <= NP; off++) begin
                if (win < 0 && (pend_rd[(last + off) % NP] || pend_wr[(last + off) % NP])) win = (last + off) % NP;
            end
            last = win;
            is_wr = pend_wr[win];
            lat = $urandom_range(0, 10);
            exp_err = (lat >= TO);
            exp_busy = exp_err ? TO : lat + 1;
            rd_val = DW'($urandom);
            if (!is_wr && !exp_err) model_prd = rd_val;
            exp_q.push_back(model_prd);

            tick();
            checks++;
            if (grant !== (4'b0001 << win) || maddr !== a_ch[win] || mrd !== !is_wr || mwr !== is_wr ||
                (is_wr && mwdata !== d_ch[win])) begin
                errors++;
                $display("FAIL rnd_grant%0d: got grant=%b maddr=%h mrd=%b mwr=%b mwd=%h, expected %b %h %b %b %h",
                         t, grant, maddr, mrd, mwr, mwdata, 4'b0001 << win, a_ch[win], !is_wr, is_wr, d_ch[win]);
            end
            // idle channels wiggle their requests during BUSY; never sampled
            rd_req = rd_req ^ (NP'($urandom) & ~(pend_rd | pend_wr));

            busy = 0;
            got = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                mem_done = (c == lat + 1);
                mem_rdata = (c == lat + 1) ? rd_val : DW'($urandom);
                tick();
                busy++;
                if (done !== '0) begin
                    got = 1'b1;
                    break;
                end
            end
            mem_done = 1'b0;
            exp_prd = exp_q.pop_front();
            checks++;
            if (!got || busy != exp_busy) begin
                errors++;
                $display("FAIL rnd_latency%0d: got done_seen=%0d busy=%0d, expected 1 %0d", t, got, busy, exp_busy);
            end
            checks++;
            if (done !== (4'b0001 << win) || err !== (exp_err ? (4'b0001 << win) : 4'b0000) || prd !== exp_prd) begin
                errors++;
                $display("FAIL rnd_resp%0d: got done=%b err=%b prd=%h, expected %b %b %h",
                         t, done, err, prd, 4'b0001 << win, exp_err ? (4'b0001 << win) : 4'b0000, exp_prd);
            end
            pend_rd[win] = 1'b0;
            pend_wr[win] = 1'b0;
            rd_req = pend_rd;
            wr_req = pend_wr;
            tick();
            checks++;
            if (grant !== '0 || done !== '0 || mrd !== 1'b0 || mwr !== 1'b0) begin
                errors++;
                $display("FAIL rnd_gap%0d: got grant=%b done=%b mrd=%b mwr=%b, expected 0000 0000 0 0", t, grant, done, mrd, mwr);
            end
        end
        rd_req = '0;
        wr_req = '0;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
